prog_loader: RTL and testbench



---
 rtl/prog_loader_if.sv | 28 ++
 rtl/prog_loader.sv | 194 +++++++++++++++++++
 tb/tb_prog_loader.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_if.sv
// Byte-stream input and program-memory write/status outputs of the program loader.
// The loader takes the slave view; the UART/bench side takes the master view.
interface prog_loader_if #(
   parameter int ADDR_W = 10
);
   logic [7:0]        BYTE_DATA;
   logic              BYTE_VALID;
   logic              BYTE_READY;
   logic              PROG_WE;
   logic [ADDR_W-1:0] PROG_WADDR;
   logic [17:0]       PROG_WDATA;
   logic              MCU_HOLD;
   logic              LOAD_BUSY;
   logic              LOAD_DONE;
   logic              LOAD_ERR;

   modport master (
      output BYTE_DATA, BYTE_VALID,
      input  BYTE_READY, PROG_WE, PROG_WADDR, PROG_WDATA,
      input  MCU_HOLD, LOAD_BUSY, LOAD_DONE, LOAD_ERR
   );

   modport slave (
      input  BYTE_DATA, BYTE_VALID,
      output BYTE_READY, PROG_WE, PROG_WADDR, PROG_WDATA,
      output MCU_HOLD, LOAD_BUSY, LOAD_DONE, LOAD_ERR
   );
endinterface

// File: rtl/prog_loader.sv
// Framed byte stream -> 18-bit program memory writes; holds the MCU in reset while loading.
// Write one cycle after B2, LOAD_DONE one cycle after CHK; BYTE_READY low only in WRITE/DONE.
// PROG_LOADER_TIMEOUT_EN adds an inter-byte timeout that forces the error state.
module prog_loader #(
   parameter int          ADDR_W         = 10,
   parameter int          DEPTH          = 1024,
   parameter logic [7:0]  START_BYTE     = 8'hA5,
   parameter int          TIMEOUT_CYCLES = 1000000
) (
   input  logic         PROG_CLK,
   input  logic         PROG_RST_N,
   prog_loader_if.slave bus
);
   typedef enum logic [3:0] {
      S_IDLE, S_CNT_HI, S_CNT_LO, S_B0, S_B1, S_B2, S_WRITE, S_CHK, S_DONE, S_ERR
   } state_t;

   localparam logic [16:0] DEPTH_N = 17'(DEPTH);

   state_t            state_q, state_d;
   logic [15:0]       cnt_q, cnt_d;
   logic [ADDR_W:0]   idx_q, idx_d;
   logic [7:0]        chk_q, chk_d;
   logic [1:0]        b0_q, b0_d;
   logic [7:0]        b1_q, b1_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [17:0]       wdata_q, wdata_d;
   logic              hold_q, hold_d;
   logic              err_q, err_d;

   logic              byte_rdy;
   logic              byte_acc;
   logic [7:0]        byte_dat;
   logic [15:0]       cnt_n;
   logic [ADDR_W:0]   idx_inc;
   logic              idx_last;

`ifdef PROG_LOADER_TIMEOUT_EN
   logic [31:0]       tmo_q, tmo_d;
`else
   logic              tmo_unused;
   assign tmo_unused = (TIMEOUT_CYCLES != 0);
`endif

   assign byte_rdy = (state_q != S_WRITE) && (state_q != S_DONE);
   assign byte_acc = bus.BYTE_VALID && byte_rdy;
   assign byte_dat = bus.BYTE_DATA;
   assign cnt_n    = {cnt_q[15:8], byte_dat};
   assign idx_inc  = idx_q + 1'b1;
   assign idx_last = ({{(15-ADDR_W){1'b0}}, idx_inc} == cnt_q);

   always_ff @(posedge PROG_CLK or negedge PROG_RST_N) begin
      if (!PROG_RST_N) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         chk_q   <= '0;
         b0_q    <= '0;
         b1_q    <= '0;
         waddr_q <= '0;
         wdata_q <= '0;
         hold_q  <= 1'b0;
         err_q   <= 1'b0;
`ifdef PROG_LOADER_TIMEOUT_EN
         tmo_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         chk_q   <= chk_d;
         b0_q    <= b0_d;
         b1_q    <= b1_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         hold_q  <= hold_d;
         err_q   <= err_d;
`ifdef PROG_LOADER_TIMEOUT_EN
         tmo_q   <= tmo_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      chk_d   = chk_q;
      b0_d    = b0_q;
      b1_d    = b1_q;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      hold_d  = hold_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE, S_ERR: begin
            if (byte_acc && byte_dat == START_BYTE) begin
               state_d = S_CNT_HI;
               hold_d  = 1'b1;
               chk_d   = '0;
               idx_d   = '0;
               err_d   = 1'b0;
            end
         end
         S_CNT_HI: begin
            if (byte_acc) begin
               cnt_d   = {byte_dat, cnt_q[7:0]};
               state_d = S_CNT_LO;
            end
         end
         S_CNT_LO: begin
            if (byte_acc) begin
               cnt_d = cnt_n;
               if (cnt_n == 16'd0 || {1'b0, cnt_n} > DEPTH_N) begin
                  state_d = S_ERR;
                  err_d   = 1'b1;
               end else begin
                  state_d = S_B0;
               end
            end
         end
         S_B0: begin
            if (byte_acc) begin
               chk_d = chk_q ^ byte_dat;
               b0_d  = byte_dat[1:0];
               if (byte_dat[7:2] != 6'd0) begin
                  state_d = S_ERR;
                  err_d   = 1'b1;
               end else begin
                  state_d = S_B1;
               end
            end
         end
         S_B1: begin
            if (byte_acc) begin
               chk_d   = chk_q ^ byte_dat;
               b1_d    = byte_dat;
               state_d = S_B2;
            end
         end
         S_B2: begin
            // Address/data are latched here so they are stable during WRITE and hold afterwards.
            if (byte_acc) begin
               chk_d   = chk_q ^ byte_dat;
               waddr_d = idx_q[ADDR_W-1:0];
               wdata_d = {b0_q, b1_q, byte_dat};
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            idx_d   = idx_inc;
            state_d = idx_last ? S_CHK : S_B0;
         end
         S_CHK: begin
            if (byte_acc) begin
               if (byte_dat == chk_q) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_ERR;
                  err_d   = 1'b1;
               end
            end
         end
         S_DONE: begin
            hold_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

`ifdef PROG_LOADER_TIMEOUT_EN
      if (byte_acc || state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR) begin
         tmo_d = '0;
      end else begin
         tmo_d = tmo_q + 32'd1;
         if (tmo_d == 32'(TIMEOUT_CYCLES)) begin
            state_d = S_ERR;
            err_d   = 1'b1;
         end
      end
`endif
   end

   always_comb begin
      bus.BYTE_READY = byte_rdy;
      bus.PROG_WE    = (state_q == S_WRITE);
      bus.PROG_WADDR = waddr_q;
      bus.PROG_WDATA = wdata_q;
      bus.MCU_HOLD   = hold_q;
      bus.LOAD_BUSY  = (state_q != S_IDLE) && (state_q != S_ERR);
      bus.LOAD_DONE  = (state_q == S_DONE);
      bus.LOAD_ERR   = err_q;
   end
endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: framed loads, error paths, reset mid-load and the optional timeout.
`timescale 1ns/1ps
module tb_prog_loader;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   prog_loader_if #(.ADDR_W(10)) bus ();

   prog_loader #(
      .ADDR_W(10), .DEPTH(1024), .START_BYTE(8'hA5), .TIMEOUT_CYCLES(50)
   ) dut (
      .PROG_CLK(clk),
      .PROG_RST_N(rst_n),
      .bus(bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   logic [9:0]  wr_addr_q[$];
   logic [17:0] wr_data_q[$];
   logic [7:0]  frm[$];
   int done_n, we_multi, we_rdy, busy_nohold;
   logic we_prev = 1'b0;

   always @(negedge clk) begin
      if (bus.PROG_WE) begin
         wr_addr_q.push_back(bus.PROG_WADDR);
         wr_data_q.push_back(bus.PROG_WDATA);
         if (bus.BYTE_READY) we_rdy++;
         if (we_prev) we_multi++;
      end
      we_prev = bus.PROG_WE;
      if (bus.LOAD_DONE) done_n++;
      if (bus.LOAD_BUSY && !bus.MCU_HOLD) busy_nohold++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic clear_mon();
      wr_addr_q.delete();
      wr_data_q.delete();
      done_n = 0; we_multi = 0; we_rdy = 0; busy_nohold = 0;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Called at posedge+1; returns at posedge+1 just after the byte was accepted.
   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      bus.BYTE_DATA  = b;
      bus.BYTE_VALID = 1'b1;
      while (!bus.BYTE_READY && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 20) check("ready_wait", {31'd0, bus.BYTE_READY}, 32'd1);
      @(posedge clk);
      #1;
      bus.BYTE_VALID = 1'b0;
   endtask

   task automatic send_frm();
      foreach (frm[i]) send_byte(frm[i]);
   endtask

   initial begin
      int bad;
      logic [9:0]  iv;
      logic [17:0] exp_w;

      bus.BYTE_DATA  = 8'h00;
      bus.BYTE_VALID = 1'b0;
      clear_mon();
      #22;
      check("rst_ready", {31'd0, bus.BYTE_READY}, 32'd1);
      check("rst_we",    {31'd0, bus.PROG_WE},    32'd0);
      check("rst_hold",  {31'd0, bus.MCU_HOLD},   32'd0);
      check("rst_busy",  {31'd0, bus.LOAD_BUSY},  32'd0);
      check("rst_done",  {31'd0, bus.LOAD_DONE},  32'd0);
      check("rst_err",   {31'd0, bus.LOAD_ERR},   32'd0);
      check("rst_waddr", {22'd0, bus.PROG_WADDR}, 32'd0);
      check("rst_wdata", {14'd0, bus.PROG_WDATA}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Two-word load; checksum 01^23^45^02^AB^CD = 03.
      clear_mon();
      frm = {8'hA5, 8'h00, 8'h02, 8'h01, 8'h23, 8'h45, 8'h02, 8'hAB, 8'hCD, 8'h03};
      send_frm();
      check("a_done_pulse", {31'd0, bus.LOAD_DONE}, 32'd1);
      check("a_hold_in_done", {31'd0, bus.MCU_HOLD}, 32'd1);
      wait_cycles(1);
      check("a_done_clr", {31'd0, bus.LOAD_DONE}, 32'd0);
      check("a_hold_rel", {31'd0, bus.MCU_HOLD},  32'd0);
      check("a_busy",     {31'd0, bus.LOAD_BUSY}, 32'd0);
      check("a_err",      {31'd0, bus.LOAD_ERR},  32'd0);
      check("a_wr_n",     wr_addr_q.size(), 32'd2);
      check("a_addr0",    {22'd0, wr_addr_q[0]}, 32'd0);
      check("a_data0",    {14'd0, wr_data_q[0]}, 32'h12345);
      check("a_addr1",    {22'd0, wr_addr_q[1]}, 32'd1);
      check("a_data1",    {14'd0, wr_data_q[1]}, 32'h2ABCD);
      check("a_done_n",   done_n, 32'd1);
      check("a_we_multi", we_multi, 32'd0);
      check("a_we_rdy",   we_rdy, 32'd0);
      check("a_busy_nohold", busy_nohold, 32'd0);
      check("a_waddr_hold", {22'd0, bus.PROG_WADDR}, 32'd1);
      check("a_wdata_hold", {14'd0, bus.PROG_WDATA}, 32'h2ABCD);

      // Non-start bytes in IDLE are swallowed.
      send_byte(8'h11);
      send_byte(8'h22);
      check("idle_busy",  {31'd0, bus.LOAD_BUSY},  32'd0);
      check("idle_hold",  {31'd0, bus.MCU_HOLD},   32'd0);
      check("idle_ready", {31'd0, bus.BYTE_READY}, 32'd1);

      // Wrong checksum 00: writes happen, error is sticky, MCU stays held.
      clear_mon();
      frm[9] = 8'h00;
      send_frm();
      check("bc_err",  {31'd0, bus.LOAD_ERR},  32'd1);
      check("bc_busy", {31'd0, bus.LOAD_BUSY}, 32'd0);
      wait_cycles(3);
      check("bc_wr_n", wr_addr_q.size(), 32'd2);
      check("bc_done_n", done_n, 32'd0);
      check("bc_err_sticky", {31'd0, bus.LOAD_ERR}, 32'd1);
      check("bc_hold", {31'd0, bus.MCU_HOLD}, 32'd1);
      // 05 is also wrong for this payload.
      clear_mon();
      frm[9] = 8'h05;
      send_frm();
      wait_cycles(1);
      check("bc5_err",    {31'd0, bus.LOAD_ERR}, 32'd1);
      check("bc5_done_n", done_n, 32'd0);
      check("bc5_wr_n",   wr_addr_q.size(), 32'd2);
      clear_mon();
      frm[9] = 8'h03;
      send_frm();
      wait_cycles(1);
      check("rec_err",    {31'd0, bus.LOAD_ERR}, 32'd0);
      check("rec_done_n", done_n, 32'd1);
      check("rec_hold",   {31'd0, bus.MCU_HOLD}, 32'd0);

      // Count and B0 format errors.
      clear_mon();
      frm = {8'hA5, 8'h00, 8'h00};
      send_frm();
      check("n0_err", {31'd0, bus.LOAD_ERR}, 32'd1);
      frm = {8'hA5, 8'h04, 8'h01};
      send_frm();
      check("n1025_err", {31'd0, bus.LOAD_ERR}, 32'd1);
      frm = {8'hA5, 8'h00, 8'h01, 8'h04};
      send_frm();
      check("b0_err", {31'd0, bus.LOAD_ERR}, 32'd1);
      check("b0_busy", {31'd0, bus.LOAD_BUSY}, 32'd0);
      wait_cycles(2);
      check("err_no_we", wr_addr_q.size(), 32'd0);

      // A5 inside the payload is data; 03^A5^5A = FC.
      clear_mon();
      frm = {8'hA5, 8'h00, 8'h01, 8'h03, 8'hA5, 8'h5A, 8'hFC};
      send_frm();
      wait_cycles(1);
      check("a5d_done_n", done_n, 32'd1);
      check("a5d_data", {14'd0, wr_data_q[0]}, 32'h3A55A);
      check("a5d_err", {31'd0, bus.LOAD_ERR}, 32'd0);

      // Full-depth load; word i = {i[9:8], i[7:0], ~i[7:0]}, whose XOR over 1024 words is 00.
      clear_mon();
      frm = {8'hA5, 8'h04, 8'h00};
      for (int i = 0; i < 1024; i++) begin
         iv = 10'(i);
         frm.push_back({6'd0, iv[9:8]});
         frm.push_back(iv[7:0]);
         frm.push_back(~iv[7:0]);
      end
      frm.push_back(8'h00);
      send_frm();
      wait_cycles(1);
      check("full_done_n", done_n, 32'd1);
      check("full_wr_n", wr_addr_q.size(), 32'd1024);
      check("full_last_addr", {22'd0, wr_addr_q[1023]}, 32'd1023);
      bad = 0;
      for (int i = 0; i < 1024; i++) begin
         iv = 10'(i);
         exp_w = {iv[9:8], iv[7:0], ~iv[7:0]};
         if (wr_addr_q[i] !== iv || wr_data_q[i] !== exp_w) bad++;
      end
      check("full_words_bad", bad, 32'd0);
      check("full_we_rdy", we_rdy, 32'd0);
      check("full_we_multi", we_multi, 32'd0);

      // Reset during the second word's WRITE cycle of a 3-word frame.
      clear_mon();
      frm = {8'hA5, 8'h00, 8'h03, 8'h01, 8'h11, 8'h11, 8'h02, 8'h22, 8'h22};
      send_frm();
      check("mid_we_pre", {31'd0, bus.PROG_WE}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_hold_async", {31'd0, bus.MCU_HOLD},  32'd0);
      check("mid_we_async",   {31'd0, bus.PROG_WE},   32'd0);
      check("mid_busy_async", {31'd0, bus.LOAD_BUSY}, 32'd0);
      #10 rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("mid_idle_busy", {31'd0, bus.LOAD_BUSY}, 32'd0);
      clear_mon();
      frm = {8'hA5, 8'h00, 8'h01, 8'h00, 8'h00, 8'h07, 8'h07};
      send_frm();
      wait_cycles(1);
      check("post_wr_n", wr_addr_q.size(), 32'd1);
      check("post_addr", {22'd0, wr_addr_q[0]}, 32'd0);
      check("post_data", {14'd0, wr_data_q[0]}, 32'h00007);
      check("post_done_n", done_n, 32'd1);

      // Stream stalls after CNT_HI.
      frm = {8'hA5, 8'h00};
      send_frm();
`ifdef PROG_LOADER_TIMEOUT_EN
      wait_cycles(49);
      check("tmo_err_early", {31'd0, bus.LOAD_ERR}, 32'd0);
      wait_cycles(1);
      check("tmo_err", {31'd0, bus.LOAD_ERR}, 32'd1);
      check("tmo_hold", {31'd0, bus.MCU_HOLD}, 32'd1);
      check("tmo_busy", {31'd0, bus.LOAD_BUSY}, 32'd0);
`else
      wait_cycles(200);
      check("stall_busy",  {31'd0, bus.LOAD_BUSY},  32'd1);
      check("stall_err",   {31'd0, bus.LOAD_ERR},   32'd0);
      check("stall_hold",  {31'd0, bus.MCU_HOLD},   32'd1);
      check("stall_ready", {31'd0, bus.BYTE_READY}, 32'd1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: time limit reached, %0d checks done", n_tests);
      $fatal(1, "watchdog");
   end
endmodule
